// File: rtl/run_continue_conditioner.sv
// Run/Continue pushbutton conditioner: two independent channels. Each channel
// synchronises its key, debounces it, and gives a clean level plus a press strobe.
module run_continue_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run_n_raw,
  input  logic Continue_n_raw,
  output logic Run,
  output logic Continue,
  output logic Run_pulse,
  output logic Continue_pulse
);

  typedef enum logic [1:0] {RELEASED, CHK_PRESS, PRESSED, CHK_REL} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       raw_n;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       pulse_q, pulse_d;
  logic [1:0]       sp;
  logic [1:0]       level;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];

  // Channel 0 is Run, channel 1 is Continue.
  assign raw_n = {Continue_n_raw, Run_n_raw};

  always_comb begin
    sync1_d = raw_n;
    sync2_d = sync1_q;
    sp      = ~sync2_q;
    pulse_d = 2'b00;
    level   = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      unique case (state_q[ch])
        RELEASED: begin
          if (sp[ch]) begin
            state_d[ch] = CHK_PRESS;
            cnt_d[ch]   = '0;
          end
        end
        CHK_PRESS: begin
          if (!sp[ch]) begin
            state_d[ch] = RELEASED;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = PRESSED;
            cnt_d[ch]   = '0;
            pulse_d[ch] = 1'b1;
          end else begin
            cnt_d[ch] = cnt_q[ch] + 1'b1;
          end
        end
        PRESSED: begin
          if (!sp[ch]) begin
            state_d[ch] = CHK_REL;
            cnt_d[ch]   = '0;
          end
        end
        CHK_REL: begin
          if (sp[ch]) begin
            state_d[ch] = PRESSED;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = RELEASED;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + 1'b1;
          end
        end
        default: begin
          state_d[ch] = RELEASED;
          cnt_d[ch]   = '0;
        end
      endcase
      // Level comes straight from the state register, so it cannot glitch.
      level[ch] = (state_q[ch] == PRESSED) || (state_q[ch] == CHK_REL);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      pulse_q <= 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= RELEASED;
        cnt_q[ch]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pulse_q <= pulse_d;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
    end
  end

  assign Run            = level[0];
  assign Continue       = level[1];
  assign Run_pulse      = pulse_q[0];
  assign Continue_pulse = pulse_q[1];

endmodule

// File: tb/tb_run_continue_conditioner.sv
// Bench for run_continue_conditioner: a run-length debounce model checked every
// cycle, plus directed scenarios with hand-computed edge-exact expectations.
module tb_run_continue_conditioner;

  localparam int D = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Run_n_raw = 1'b1;
  logic Continue_n_raw = 1'b1;
  logic Run, Continue, Run_pulse, Continue_pulse;

  int total = 0;
  int bad = 0;
  int run_pc = 0;
  int cont_pc = 0;
  bit chk_en = 1'b0;

  run_continue_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Run_n_raw(Run_n_raw), .Continue_n_raw(Continue_n_raw),
    .Run(Run), .Continue(Continue), .Run_pulse(Run_pulse), .Continue_pulse(Continue_pulse)
  );

  always #5 Clk = ~Clk;

  // Model: after a two-sample delay, the level flips once D+1 consecutive
  // pressed/released samples disagree with it; a press flip strobes for one cycle.
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_lvl [2];
  logic m_pl [2];
  int   m_run [2];

  always @(posedge Clk) begin
    logic raw [2];
    logic smp;
    raw[0] = Run_n_raw;
    raw[1] = Continue_n_raw;
    for (int ch = 0; ch < 2; ch++) begin
      if (Reset) begin
        m_s1[ch] = 1'b1; m_s2[ch] = 1'b1;
        m_lvl[ch] = 1'b0; m_pl[ch] = 1'b0; m_run[ch] = 0;
      end else begin
        smp = ~m_s2[ch];
        m_run[ch] = (smp != m_lvl[ch]) ? m_run[ch] + 1 : 0;
        m_pl[ch] = 1'b0;
        if (m_run[ch] == D + 1) begin
          m_lvl[ch] = smp;
          m_pl[ch]  = smp;
          m_run[ch] = 0;
        end
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = raw[ch];
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Wait until just after the k-th edge counted from 0 (first edge after a negedge drive).
  task automatic after_edge(input int k);
    repeat (k + 1) @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    fork
      begin : compare
        forever begin
          @(negedge Clk);
          if (Run_pulse) run_pc++;
          if (Continue_pulse) cont_pc++;
          if (chk_en) begin
            total++;
            if ({Run, Continue, Run_pulse, Continue_pulse} !==
                {m_lvl[0], m_lvl[1], m_pl[0], m_pl[1]}) begin
              bad++;
              $display("FAIL model: got R=%b C=%b Rp=%b Cp=%b want R=%b C=%b Rp=%b Cp=%b at %0t",
                       Run, Continue, Run_pulse, Continue_pulse,
                       m_lvl[0], m_lvl[1], m_pl[0], m_pl[1], $time);
            end
          end
        end
      end
      begin : stimulus
        int base_r, base_c;
        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_run", Run, 1'b0);
        chk("reset_cont", Continue, 1'b0);
        chk("reset_rpulse", Run_pulse, 1'b0);
        chk("reset_cpulse", Continue_pulse, 1'b0);
        chk_en = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        idle(4);

        // Clean press on Run
        base_r = run_pc;
        Run_n_raw = 1'b0;
        after_edge(5);
        chk("press_run_e5", Run, 1'b0);
        @(posedge Clk); #1;
        chk("press_run_e6", Run, 1'b1);
        chk("press_rpulse_e6", Run_pulse, 1'b1);
        chk("press_cont_e6", Continue, 1'b0);
        @(posedge Clk); #1;
        chk("press_rpulse_e7", Run_pulse, 1'b0);
        chk("press_run_e7", Run, 1'b1);
        @(negedge Clk); Run_n_raw = 1'b1;
        idle(10);
        chk("press_run_released", Run, 1'b0);
        chk_int("press_rpulse_count", run_pc - base_r, 1);

        // Bounce on Continue, then final low and held
        base_c = cont_pc;
        Continue_n_raw = 1'b0;
        idle(3);
        Continue_n_raw = 1'b1;
        idle(1);
        Continue_n_raw = 1'b0;
        after_edge(5);
        chk("bounce_cont_e5", Continue, 1'b0);
        @(posedge Clk); #1;
        chk("bounce_cont_e6", Continue, 1'b1);
        chk("bounce_cpulse_e6", Continue_pulse, 1'b1);
        idle(20);
        // Release half of the handshake
        Continue_n_raw = 1'b1;
        after_edge(5);
        chk("release_cont_e5", Continue, 1'b1);
        @(posedge Clk); #1;
        chk("release_cont_e6", Continue, 1'b0);
        chk("release_cpulse_e6", Continue_pulse, 1'b0);
        idle(5);
        chk_int("bounce_cpulse_count", cont_pc - base_c, 1);

        // Simultaneous keys
        base_r = run_pc; base_c = cont_pc;
        Run_n_raw = 1'b0; Continue_n_raw = 1'b0;
        after_edge(6);
        chk("simul_run", Run, 1'b1);
        chk("simul_cont", Continue, 1'b1);
        chk("simul_rpulse", Run_pulse, 1'b1);
        chk("simul_cpulse", Continue_pulse, 1'b1);
        @(negedge Clk); Run_n_raw = 1'b1; Continue_n_raw = 1'b1;
        idle(10);
        chk_int("simul_rpulse_count", run_pc - base_r, 1);
        chk_int("simul_cpulse_count", cont_pc - base_c, 1);

        // Reset mid-qualification, key held through it
        base_r = run_pc;
        Run_n_raw = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk); Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(posedge Clk); #1;
          chk("rst_mid_run_in_reset", Run, 1'b0);
        end
        @(negedge Clk); Reset = 1'b0;
        after_edge(5);
        chk("rst_mid_run_k5", Run, 1'b0);
        @(posedge Clk); #1;
        chk("rst_mid_run_k6", Run, 1'b1);
        chk("rst_mid_rpulse_k6", Run_pulse, 1'b1);
        idle(5);
        chk_int("rst_mid_rpulse_count", run_pc - base_r, 1);

        // Short release glitch while Run is held
        base_r = run_pc;
        Run_n_raw = 1'b1;
        idle(2);
        Run_n_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
          @(posedge Clk); #1;
          chk("glitch_run_held", Run, 1'b1);
        end
        chk_int("glitch_rpulse_count", run_pc - base_r, 0);
        @(negedge Clk); Run_n_raw = 1'b1;
        idle(10);
        chk("glitch_final_release", Run, 1'b0);
        chk_en = 1'b0;
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
